// File: rtl/obstacle_ctrl.sv
// Obstacle controller: moves four lanes of cars on a prescaled tick, detects raccoon/car
// overlap, and stretches each hit into a long collision pulse followed by a cooldown.
module obstacle_ctrl #(
  parameter int GAME_WIDTH      = 640,
  parameter int GAME_HEIGHT     = 480,
  parameter int GRID_HEIGHT     = 32,
  parameter int PLAYER_WIDTH    = 32,
  parameter int CAR_WIDTH       = 64,
  parameter int TICK_DIV        = 250000,
  parameter int HOLD_CYCLES     = 8388608,
  parameter int COOLDOWN_CYCLES = 8388608
) (
  input  logic        i_Clk,
  input  logic        i_Reset,
  input  logic [9:0]  i_Raccoon_X,
  input  logic [9:0]  i_Raccoon_Y,
  input  logic [3:0]  i_Level,
  output logic        o_Collision,
  output logic [39:0] o_Car_X,
  output logic [39:0] o_Car_Y,
  output logic [7:0]  o_Hit_Count
);

  localparam int TICK_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CNT_MAX = (HOLD_CYCLES > COOLDOWN_CYCLES) ? HOLD_CYCLES : COOLDOWN_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [10:0]       GW        = 11'(GAME_WIDTH);
  localparam logic [10:0]       CW        = 11'(CAR_WIDTH);
  localparam logic [10:0]       PW        = 11'(PLAYER_WIDTH);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]  HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0]  COOL_LOAD = CNT_W'(COOLDOWN_CYCLES - 1);

  typedef enum logic [1:0] {ARMED, HIT, COOLDOWN} state_e;

  function automatic logic [9:0] lane_y(input int k);
    return 10'(GAME_HEIGHT - (k + 2) * GRID_HEIGHT);
  endfunction

  function automatic logic [9:0] lane_x0(input int k);
    return 10'(k * (GAME_WIDTH / 4));
  endfunction

  logic [TICK_W-1:0] presc_q, presc_d;
  logic [9:0]        car_x_q [4];
  logic [9:0]        car_x_d [4];
  logic              hit_q, hit_d;
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              collision_q, collision_d;
  logic [7:0]        hit_count_q, hit_count_d;

  logic        tick;
  logic [3:0]  eff_level;
  logic [10:0] step, x_cur, x_sum, x_next, x_end, rx;
  logic        direct, wrapped;

  // Car motion and overlap both look at the registered (pre-move) positions.
  always_comb begin
    tick      = (presc_q == TICK_LAST);
    presc_d   = tick ? '0 : presc_q + 1'b1;
    eff_level = i_Level;
    if (i_Level == 4'd0)     eff_level = 4'd1;
    else if (i_Level > 4'd9) eff_level = 4'd9;
    step    = '0;
    x_cur   = '0;
    x_sum   = '0;
    x_next  = '0;
    x_end   = '0;
    direct  = 1'b0;
    wrapped = 1'b0;
    rx      = {1'b0, i_Raccoon_X};
    hit_d   = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step  = 11'(eff_level) + 11'(k);
      x_cur = {1'b0, car_x_q[k]};
      x_sum = x_cur + step;
      if (k % 2 == 0) x_next = (x_sum >= GW) ? x_sum - GW : x_sum;
      else            x_next = (x_cur < step) ? x_cur + GW - step : x_cur - step;
      car_x_d[k] = tick ? x_next[9:0] : car_x_q[k];

      x_end   = x_cur + CW;
      direct  = (rx < x_end) && (rx + PW > x_cur);
      wrapped = (x_end > GW) && (rx < x_end - GW);
      if ((i_Raccoon_Y == lane_y(k)) && (direct || wrapped)) hit_d = 1'b1;
    end
  end

  // Hits only register in ARMED; the hold and cooldown windows share one counter.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    collision_d = collision_q;
    hit_count_d = hit_count_q;
    case (state_q)
      ARMED: begin
        if (hit_q) begin
          state_d     = HIT;
          cnt_d       = HOLD_LOAD;
          collision_d = 1'b1;
          if (hit_count_q != 8'hFF) hit_count_d = hit_count_q + 8'd1;
        end
      end
      HIT: begin
        if (cnt_q == '0) begin
          state_d     = COOLDOWN;
          cnt_d       = COOL_LOAD;
          collision_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      COOLDOWN: begin
        if (cnt_q == '0) state_d = ARMED;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d     = ARMED;
        collision_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      presc_q     <= '0;
      hit_q       <= 1'b0;
      state_q     <= ARMED;
      cnt_q       <= '0;
      collision_q <= 1'b0;
      hit_count_q <= '0;
      for (int k = 0; k < 4; k++) car_x_q[k] <= lane_x0(k);
    end else begin
      presc_q     <= presc_d;
      hit_q       <= hit_d;
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      collision_q <= collision_d;
      hit_count_q <= hit_count_d;
      for (int k = 0; k < 4; k++) car_x_q[k] <= car_x_d[k];
    end
  end

  always_comb begin
    o_Car_X = '0;
    o_Car_Y = '0;
    for (int k = 0; k < 4; k++) begin
      o_Car_X[10*k +: 10] = car_x_q[k];
      o_Car_Y[10*k +: 10] = lane_y(k);
    end
  end

  assign o_Collision = collision_q;
  assign o_Hit_Count = hit_count_q;

endmodule

// File: doc/obstacle_ctrl.md
Name: obstacle_ctrl

Overview:
- Generates the moving cars for the road lanes and drives the collision signal consumed by the raccoon position controller.
- Closes the loop on that controller: takes its X/Y position and level, and returns a collision pulse held long enough for its slow-clock sampler to see it.
- Also exports car positions for the VGA renderer.

Parameters:
GAME_WIDTH, 640, playfield width in pixels
GAME_HEIGHT, 480, playfield height in pixels
GRID_HEIGHT, 32, row pitch in pixels
PLAYER_WIDTH, 32, raccoon sprite width
CAR_WIDTH, 64, car sprite width
TICK_DIV, 250000, i_Clk cycles per car movement tick
HOLD_CYCLES, 8388608, cycles o_Collision stays high per hit
COOLDOWN_CYCLES, 8388608, cycles after a hold during which hits are ignored

Ports:
i_Clk  in  1  system clock
i_Reset  in  1  synchronous active-high reset
i_Raccoon_X  in  10  raccoon left edge, pixels
i_Raccoon_Y  in  10  raccoon top edge, grid-aligned
i_Level  in  4  current level (1..9)
o_Collision  out  1  collision flag to the raccoon controller
o_Car_X  out  40  four 10-bit car left edges; lane k at bits [10k+9:10k]
o_Car_Y  out  40  four 10-bit car top edges, constant per lane
o_Hit_Count  out  8  saturating count of hits since reset

Behaviour:
- One clock domain, i_Clk. i_Reset is synchronous and active-high, and overrides everything.
- Reset values:
  - o_Car_X lane k = k*160.
  - o_Collision = 0.
  - o_Hit_Count = 0.
  - FSM = ARMED.
  - Tick prescaler = 0.
  - Hold/cooldown counter = 0.
- Lane rows: lane k Y = GAME_HEIGHT - (k+2)*GRID_HEIGHT, giving 416/384/352/320 at defaults. o_Car_Y is driven constant.
- Lane direction: even lanes move right, odd lanes move left.
- Tick: the prescaler counts 0..TICK_DIV-1. A one-cycle tick fires when it wraps.
- Speed:
  - eff_level = 1 if i_Level==0; 9 if i_Level>9; else i_Level.
  - step_k = eff_level + k pixels per tick, range 1..12.
- Movement on tick, with wrap-around in 11-bit arithmetic:
  - Right: X+step >= GAME_WIDTH → X <= X+step-GAME_WIDTH, else X+step.
  - Left: X < step → X <= X+GAME_WIDTH-step, else X-step.
  - X is always in 0..GAME_WIDTH-1.
- Overlap for lane k, combinational, using 11-bit sums:
  - Row match: i_Raccoon_Y == lane Y.
  - Direct overlap: i_Raccoon_X < X+CAR_WIDTH AND i_Raccoon_X+PLAYER_WIDTH > X.
  - Wrapped overlap: if X+CAR_WIDTH > GAME_WIDTH, also overlap when i_Raccoon_X < X+CAR_WIDTH-GAME_WIDTH.
  - hit = OR over lanes of (row match AND (direct OR wrapped)).
  - hit is registered, giving one cycle of latency from input change or car move to hit_q.
- FSM:
  - ARMED: hit_q=1 → HIT; counter <= HOLD_CYCLES-1; o_Collision <= 1; o_Hit_Count += 1, saturating at 255.
  - HIT: o_Collision=1; counter decrements; at 0 → COOLDOWN; counter <= COOLDOWN_CYCLES-1; o_Collision <= 0. Further hits are ignored.
  - COOLDOWN: o_Collision=0; hits are ignored; at 0 → ARMED.
- Cars keep moving in all FSM states.
- Simultaneous hits in several lanes count as one hit.
- A tick coinciding with a hit: the comparison uses the pre-move registered X for that cycle.
- Reset mid-HIT: o_Collision drops on the next edge; the hit is not recounted.
- Level change takes effect on the next tick. Car positions are not reset on level change.

Test Plan:
- Reset; override TICK_DIV=4 -> after reset o_Car_X = {480,320,160,0}, o_Collision=0; after 4 cycles with i_Level=1 lane0 X=1, lane1 X=158, lane2 X=323, lane3 X=476.
- Lane0 at X=636, i_Level=1, tick -> X=637; with i_Level=12 (clamped to 9) at X=636 -> X=5 (wrap right).
- Lane1 at X=3, i_Level=3 (step 4), tick -> X=639 (wrap left).
- HOLD_CYCLES=8, COOLDOWN_CYCLES=8; raccoon Y=416, X=lane0 X+10 -> o_Collision rises 2 cycles later and stays high exactly 8 cycles; o_Hit_Count=1; raccoon held in place, no new hit for 8 further cycles, then a second hit with o_Hit_Count=2.
- Lane0 X=600 (wrapped segment 0..23), raccoon Y=416, X=10 -> collision; raccoon X=24 -> no collision; raccoon Y=448, X=600 -> no collision.
- Assert i_Reset during HIT -> o_Collision=0 and FSM ARMED next cycle, cars back at initial X, o_Hit_Count=0.
